calc_seq_ctrl: RTL
==================

CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 20000, debounce stable-time in clk cycles.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before abort.
REQ-003 SHALL have port clk  in  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port button  in  1  raw asynchronous push-button.
REQ-006 SHALL have ports func/num1/num2  in  3/8/8  operation code and operands from switches.
REQ-007 SHALL have ports alu_a/alu_b/alu_func  out  8/8/3  latched operands and opcode to the arithmetic datapath.
REQ-008 SHALL have port alu_start  out  1  one-cycle operation launch pulse.
REQ-009 SHALL have ports alu_done/alu_err  in  1/1  datapath completion pulse and error flag, valid with done.
REQ-010 SHALL have port alu_result  in  32  datapath result, valid with alu_done.
REQ-011 SHALL have ports cal_result/button_new  out  32/1  held result and one-cycle display-refresh pulse.
REQ-012 SHALL have ports busy/err  out  1/1  operation in flight; sticky error.

Function
REQ-013 SHALL pass button through a 2-flop synchronizer; a press event is the rising edge of the filtered level.
REQ-014 SHALL use FSM states IDLE, LATCH, START, WAIT, UPDATE.
REQ-015 SHALL, in IDLE on press event at cycle E, enter LATCH at E+1 and capture func/num1/num2 into alu_func/alu_a/alu_b.
REQ-016 SHALL, if the latched func is 3'b111 (clear), skip START/WAIT: UPDATE at E+2 loads cal_result=0, clears err.
REQ-017 SHALL otherwise assert alu_start for exactly one cycle in START (E+2), then enter WAIT.
REQ-018 SHALL, in WAIT, count cycles from 0; alu_done sampled high moves to UPDATE next cycle.
REQ-019 SHALL, in UPDATE, load cal_result=alu_result when alu_err=0, else keep cal_result and set err.
REQ-020 SHALL pulse button_new for exactly one cycle in UPDATE (every path, including error), then return to IDLE.
REQ-021 SHALL abort when WAIT count reaches TIMEOUT_CYCLES without alu_done: set err, keep cal_result, no button_new, return to IDLE.
REQ-022 SHALL ignore press events while not in IDLE (no queueing) and ignore alu_done outside WAIT.
REQ-023 SHALL clear err on the next accepted press (LATCH entry).
REQ-024 SHALL drive busy high in LATCH, START, WAIT, UPDATE; low in IDLE.
REQ-025 SHALL hold alu_a/alu_b/alu_func stable from LATCH until the next LATCH.
REQ-026 SHALL treat alu_done arriving in the same cycle as the timeout terminal count as done (done wins).

Reset
REQ-027 SHALL, on rst, asynchronously enter IDLE and zero cal_result, alu_a, alu_b, alu_func, alu_start, button_new, busy, err, counters, synchronizer and filter.
REQ-028 SHALL, on rst mid-operation, discard the operation; a later alu_done is ignored (REQ-022).

Configuration
REQ-029 SHALL honour macro CALC_DEBOUNCE_EN: defined -> filtered level changes only after DEB_CYCLES consecutive identical synchronized samples; undefined -> filtered level equals synchronized level (no counter, DEB_CYCLES unused).

Structure
REQ-030 SHALL take opcode constants (ADD=000, SUB=001, MUL=010, DIV=011, AND=100, OR=101, XOR=110, CLR=111) and the FSM state enum from shared package calc_pkg.
REQ-031 SHALL place synchronizer, debounce and edge detect in sub-module calc_btn_filter (ports clk, rst, btn_in, press).

Verification
REQ-032 SHALL cover: DEB_CYCLES=4, button bounces 1-0-1 in 3 cycles then held -> exactly one press, alu_start once.
REQ-033 SHALL cover: func=000, num1=8'h12, num2=8'h34, done 3 cycles after start with result 32'h46 -> cal_result=32'h46, button_new one cycle, busy low after.
REQ-034 SHALL cover: func=111 after result 32'h46 -> cal_result=0 with no alu_start, err cleared.
REQ-035 SHALL cover: func=011, num2=0, done with alu_err=1 -> err=1, cal_result unchanged, button_new pulses; next press clears err.
REQ-036 SHALL cover: TIMEOUT_CYCLES=8, alu_done never asserted -> err=1 after 8 WAIT cycles, no button_new, second press during WAIT ignored.
REQ-037 SHALL cover: rst asserted in WAIT, late alu_done -> all outputs zero, cal_result stays 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcode constants and controller state encoding for the calculator sequencer.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_START,
    ST_WAIT,
    ST_UPDATE
  } state_t;

endpackage

// File: rtl/calc_btn_filter.sv
// Push-button conditioning: 2-flop synchronizer, optional debounce (CALC_DEBOUNCE_EN),
// and rising-edge detect producing a one-cycle press pulse.
module calc_btn_filter
  import calc_pkg::*;
#(
  parameter int DEB_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press
);

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic level_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;

  // The counter tracks consecutive samples that disagree with the filtered level;
  // any agreeing sample restarts it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= level;
    end
  end

  assign press = level & ~level_prev_q;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: button press latches switches, launches the datapath and
// holds the result. Debounce is enabled by defining CALC_DEBOUNCE_EN.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int DEB_CYCLES     = 20000,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic [2:0]  func,
  input  logic [7:0]  num1,
  input  logic [7:0]  num2,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_func,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic        alu_err,
  input  logic [31:0] alu_result,
  output logic [31:0] cal_result,
  output logic        button_new,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TERM = CW'(TIMEOUT_CYCLES - 1);

  logic          press;
  state_t        state_q, state_d;
  logic [7:0]    alu_a_q, alu_a_d;
  logic [7:0]    alu_b_q, alu_b_d;
  logic [2:0]    alu_func_q, alu_func_d;
  logic [31:0]   cal_q, cal_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  calc_btn_filter #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_filter (
    .clk   (clk),
    .rst   (rst),
    .btn_in(button),
    .press (press)
  );

  // Result and error are registered on the way into UPDATE so the new value is
  // already on cal_result while button_new pulses.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_func_d = alu_func_q;
    cal_d      = cal_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d    = ST_LATCH;
          alu_func_d = func;
          alu_a_d    = num1;
          alu_b_d    = num2;
          err_d      = 1'b0;
        end
      end
      ST_LATCH: begin
        if (alu_func_q == OP_CLR) begin
          state_d = ST_UPDATE;
          cal_d   = '0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // A done on the terminal-count cycle still completes normally.
        if (alu_done) begin
          state_d = ST_UPDATE;
          if (alu_err) begin
            err_d = 1'b1;
          end else begin
            cal_d = alu_result;
          end
        end else if (cnt_q == CNT_TERM) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= '0;
      cal_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
      cal_q      <= cal_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_func   = alu_func_q;
  assign cal_result = cal_q;
  assign err        = err_q;
  assign alu_start  = (state_q == ST_START);
  assign button_new = (state_q == ST_UPDATE);
  assign busy       = (state_q != ST_IDLE);

endmodule
